// File: rtl/apb3_requester_arbiter.sv
// Round-robin arbiter sharing one APB3 bus among several requesters.
// Registered APB outputs, wait-state handling and a bounded ACCESS phase.
module apb3_requester_arbiter #(
  parameter int NumRequesters = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumRequesters-1:0]           req_valid,
  input  logic [NumRequesters-1:0]           req_write,
  input  logic [NumRequesters*AddrWidth-1:0] req_addr,
  input  logic [NumRequesters*DataWidth-1:0] req_wdata,
  output logic [NumRequesters-1:0]           req_ready,
  output logic [DataWidth-1:0]               rsp_rdata,
  output logic                               rsp_err,
  output logic                               timeout_evt,
  output logic [AddrWidth-1:0]               paddr,
  output logic                               psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [DataWidth-1:0]               pwdata,
  input  logic [DataWidth-1:0]               prdata,
  input  logic                               pready,
  input  logic                               pslverr
);

  localparam int IdxW = $clog2(NumRequesters);
  localparam int CntW =
    (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
  localparam logic ToEn = (TimeoutCycles > 0);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRequesters - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [AddrWidth-1:0] paddr_q, paddr_d;
  logic [DataWidth-1:0] pwdata_q, pwdata_d;

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] win_next;
  logic            in_access;
  logic            timeout_hit;
  logic            done;

  // Search from the rr pointer, wrapping around the requester ring.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < NumRequesters; k++) begin
      j = int'(rr_q) + k;
      if (j >= NumRequesters) j = j - NumRequesters;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(j);
      end
    end
  end

  assign win_next = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;

  assign in_access   = (state_q == S_ACCESS);
  assign timeout_hit = ToEn && in_access && !pready && (cnt_q == CntMax);
  assign done        = in_access && (pready || timeout_hit);

  always_comb begin
    req_ready = '0;
    if (done) req_ready[grant_q] = 1'b1;
  end

  // A timed-out read returns zero data; writes never return data.
  assign rsp_rdata   = (done && pready && !pwrite_q) ? prdata : '0;
  assign rsp_err     = done && (pready ? pslverr : 1'b1);
  assign timeout_evt = timeout_hit;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d  = win_idx;
          rr_d     = win_next;
          paddr_d  = req_addr[int'(win_idx)*AddrWidth +: AddrWidth];
          pwdata_d = req_wdata[int'(win_idx)*DataWidth +: DataWidth];
          pwrite_d = req_write[win_idx];
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb3_requester_arbiter.sv
// Directed bench for apb3_requester_arbiter.
// Four requesters, 4-cycle timeout, hand-computed expectations.
module tb_apb3_requester_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            timeout_evt;
  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  int n_chk  = 0;
  int n_fail = 0;

  apb3_requester_arbiter #(
    .NumRequesters(N),
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .timeout_evt(timeout_evt),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    // reset values
    #12;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_tevt", 32'(timeout_evt), 32'd0);
    step;
    rst_n = 1'b1;

    // single read, requester 0
    req_valid = 4'b0001;
    req_addr[0*AW +: AW] = 32'h1000;
    pready = 1'b1;
    prdata = 32'hDEADBEEF;
    #1;
    chk("t1_idle_psel", 32'(psel), 32'd0);
    step;
    #1;
    chk("t1_setup_psel", 32'(psel), 32'd1);
    chk("t1_setup_pen", 32'(penable), 32'd0);
    chk("t1_setup_addr", paddr, 32'h1000);
    chk("t1_setup_ready", 32'(req_ready), 32'd0);
    step;
    #1;
    chk("t1_acc_psel", 32'(psel), 32'd1);
    chk("t1_acc_pen", 32'(penable), 32'd1);
    chk("t1_ready", 32'(req_ready), 32'b0001);
    chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1_err", 32'(rsp_err), 32'd0);
    step;
    req_valid = '0;
    #1;
    chk("t1_after_psel", 32'(psel), 32'd0);
    chk("t1_after_ready", 32'(req_ready), 32'd0);

    // write with 3 wait states, requester 2
    req_valid = 4'b0100;
    req_write = 4'b0100;
    req_addr[2*AW +: AW]  = 32'h20;
    req_wdata[2*DW +: DW] = 32'h12345678;
    pready = 1'b0;
    step;
    req_addr[2*AW +: AW]  = 32'hFFFF;
    req_wdata[2*DW +: DW] = 32'h0;
    #1;
    chk("t2_setup_addr", paddr, 32'h20);
    chk("t2_setup_wdata", pwdata, 32'h12345678);
    chk("t2_setup_pwrite", 32'(pwrite), 32'd1);
    for (int w = 0; w < 3; w++) begin
      step;
      #1;
      chk("t2_wait_pen", 32'(penable), 32'd1);
      chk("t2_wait_addr", paddr, 32'h20);
      chk("t2_wait_wdata", pwdata, 32'h12345678);
      chk("t2_wait_ready", 32'(req_ready), 32'd0);
    end
    step;
    pready = 1'b1;
    #1;
    chk("t2_last_addr", paddr, 32'h20);
    chk("t2_last_wdata", pwdata, 32'h12345678);
    chk("t2_ready", 32'(req_ready), 32'b0100);
    chk("t2_rdata", rsp_rdata, 32'd0);
    chk("t2_err", 32'(rsp_err), 32'd0);
    step;
    req_valid = '0;
    req_write = '0;
    #1;
    chk("t2_after_psel", 32'(psel), 32'd0);

    // all requesters busy after a fresh reset
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++)
      req_addr[i*AW +: AW] = 32'h100 * (i + 1);
    req_valid = 4'hF;
    pready    = 1'b1;
    prdata    = 32'hA5A50000;
    for (int t = 0; t < 6; t++) begin
      #1;
      chk("t3_idle_psel", 32'(psel), 32'd0);
      step;
      #1;
      chk("t3_setup_addr", paddr, 32'h100 * ((t % N) + 1));
      step;
      #1;
      chk("t3_grant", 32'(req_ready), 32'(1 << (t % N)));
      step;
    end
    req_valid = '0;

    // timeout on requester 1; pslverr during waits is ignored
    req_valid = 4'b0010;
    pready    = 1'b0;
    pslverr   = 1'b1;
    prdata    = 32'h55AA55AA;
    step;
    step;
    for (int a = 1; a <= TO; a++) begin
      #1;
      chk("t4_wait_ready", 32'(req_ready), 32'd0);
      chk("t4_wait_tevt", 32'(timeout_evt), 32'd0);
      step;
    end
    #1;
    chk("t4_to_ready", 32'(req_ready), 32'b0010);
    chk("t4_to_tevt", 32'(timeout_evt), 32'd1);
    chk("t4_to_err", 32'(rsp_err), 32'd1);
    chk("t4_to_rdata", rsp_rdata, 32'd0);
    step;
    req_valid = '0;
    pslverr   = 1'b0;
    #1;
    chk("t4_after_psel", 32'(psel), 32'd0);
    chk("t4_after_tevt", 32'(timeout_evt), 32'd0);

    // pready arrives in the timeout cycle: normal completion
    req_valid = 4'b0010;
    repeat (6) step;
    pready = 1'b1;
    #1;
    chk("t4b_ready", 32'(req_ready), 32'b0010);
    chk("t4b_tevt", 32'(timeout_evt), 32'd0);
    chk("t4b_err", 32'(rsp_err), 32'd0);
    chk("t4b_rdata", rsp_rdata, 32'h55AA55AA);
    step;
    req_valid = '0;

    // slave error on requester 3, then clean read on requester 0
    req_valid = 4'b1000;
    pslverr   = 1'b1;
    prdata    = 32'h0BADF00D;
    step;
    step;
    #1;
    chk("t5_ready", 32'(req_ready), 32'b1000);
    chk("t5_err", 32'(rsp_err), 32'd1);
    chk("t5_rdata", rsp_rdata, 32'h0BADF00D);
    step;
    req_valid = 4'b0001;
    pslverr   = 1'b0;
    #1;
    chk("t5_idle_err", 32'(rsp_err), 32'd0);
    chk("t5_idle_psel", 32'(psel), 32'd0);
    step;
    step;
    #1;
    chk("t5b_ready", 32'(req_ready), 32'b0001);
    chk("t5b_err", 32'(rsp_err), 32'd0);
    step;
    req_valid = '0;

    // reset during ACCESS, then requester 0 wins first
    req_valid = 4'b0100;
    pready    = 1'b0;
    step;
    step;
    #1;
    chk("t6_acc_pen", 32'(penable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_psel", 32'(psel), 32'd0);
    chk("t6_rst_pen", 32'(penable), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    step;
    req_valid = 4'b0101;
    pready    = 1'b1;
    rst_n     = 1'b1;
    step;
    #1;
    chk("t6_setup_addr", paddr, 32'h100);
    step;
    #1;
    chk("t6_ready", 32'(req_ready), 32'b0001);
    step;
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
